// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the transmitter and the mic-side receiver,
// so that both ends of the audio path agree on frame geometry.
package i2s_pkg;

  localparam int SLOT_BITS         = 32;
  localparam int FRAME_BITS        = 64;
  localparam int DEFAULT_BCLK_HALF = 12;

  typedef logic signed [15:0] i2s_sample_t;

  typedef struct packed {
    i2s_sample_t left;
    i2s_sample_t right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit/word clock generator: divides the system clock into BCLK, counts
// BCLKs within the frame and derives LRCLK from the frame bit counter.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF = DEFAULT_BCLK_HALF,
  parameter int SLOT_BITS = i2s_pkg::SLOT_BITS,
  localparam int BC_W     = $clog2(2 * SLOT_BITS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic            bclk_o,
  output logic            lrclk_o,
  output logic [BC_W-1:0] bc_o,
  output logic            fall_o,
  output logic            wrap_o
);

  localparam int              HC_W    = $clog2(BCLK_HALF + 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(BCLK_HALF - 1);

  logic [HC_W-1:0] hc_q, hc_d;
  logic            bclk_q, bclk_d;
  logic            lrclk_q, lrclk_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic            fall;

  // The falling edge is the system cycle in which BCLK is about to go 1->0.
  assign fall = (hc_q == HC_LAST) && bclk_q;

  always_comb begin
    hc_d    = hc_q + 1'b1;
    bclk_d  = bclk_q;
    bc_d    = bc_q;
    lrclk_d = lrclk_q;
    if (hc_q == HC_LAST) begin
      hc_d   = '0;
      bclk_d = ~bclk_q;
    end
    if (fall) begin
      bc_d    = bc_q + 1'b1;
      lrclk_d = bc_d[BC_W-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hc_q    <= '0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      bc_q    <= '0;
    end else begin
      hc_q    <= hc_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      bc_q    <= bc_d;
    end
  end

  assign bclk_o  = bclk_q;
  assign lrclk_o = lrclk_q;
  assign bc_o    = bc_q;
  assign fall_o  = fall;
  assign wrap_o  = fall && (bc_q == '1);

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: one-deep sample-pair buffer filled by a valid/ready
// handshake, loaded at each frame boundary and shifted out MSB-first.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int BCLK_HALF    = DEFAULT_BCLK_HALF,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = i2s_pkg::SLOT_BITS
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic                    i2s_bclk_out,
  output logic                    i2s_lrclk_out,
  output logic                    i2s_data_out,
  output logic                    frame_start_out,
  output logic                    underrun_out
);

  localparam int BC_W   = $clog2(2 * SLOT_BITS);
  localparam int SLOT_W = $clog2(SLOT_BITS);

  logic [BC_W-1:0] bc;
  logic            fall, wrap;

  i2s_clkgen #(
    .BCLK_HALF(BCLK_HALF),
    .SLOT_BITS(SLOT_BITS)
  ) u_clkgen (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .bclk_o (i2s_bclk_out),
    .lrclk_o(i2s_lrclk_out),
    .bc_o   (bc),
    .fall_o (fall),
    .wrap_o (wrap)
  );

  logic [SAMPLE_WIDTH-1:0] pendLeft_q, pendLeft_d, pendRight_q, pendRight_d;
  logic [SAMPLE_WIDTH-1:0] actLeft_q, actLeft_d, actRight_q, actRight_d;
  logic                    pendFull_q, pendFull_d;
  logic                    ready_q, ready_d;
  logic                    data_q, data_d;
  logic                    frameStart_q, frameStart_d;
  logic                    underrun_q, underrun_d;

  logic [BC_W-1:0]         newBc;
  logic [SAMPLE_WIDTH-1:0] slotWord, shifted;
  logic                    serialBit;
  int                      slotPos;

  // Bit for the BCLK slot being entered: slot position 0 is the I2S delay bit.
  always_comb begin
    newBc     = bc + 1'b1;
    slotPos   = int'(newBc[SLOT_W-1:0]);
    slotWord  = newBc[BC_W-1] ? actRight_q : actLeft_q;
    shifted   = '0;
    serialBit = 1'b0;
    if (slotPos >= 1 && slotPos <= SAMPLE_WIDTH) begin
      shifted   = slotWord << (slotPos - 1);
      serialBit = shifted[SAMPLE_WIDTH-1];
    end
  end

  always_comb begin
    pendLeft_d   = pendLeft_q;
    pendRight_d  = pendRight_q;
    pendFull_d   = pendFull_q;
    actLeft_d    = actLeft_q;
    actRight_d   = actRight_q;
    data_d       = data_q;
    frameStart_d = 1'b0;
    underrun_d   = 1'b0;
    if (valid_in && ready_q) begin
      pendLeft_d  = left_in;
      pendRight_d = right_in;
      pendFull_d  = 1'b1;
    end
    if (fall) begin
      data_d = serialBit;
    end
    // A pair accepted on the boundary cycle is not yet visible here, so it
    // waits for the next frame and this one goes out silent.
    if (wrap) begin
      frameStart_d = 1'b1;
      if (pendFull_q) begin
        actLeft_d  = pendLeft_q;
        actRight_d = pendRight_q;
        pendFull_d = 1'b0;
      end else begin
        actLeft_d  = '0;
        actRight_d = '0;
        underrun_d = 1'b1;
      end
    end
    ready_d = ~pendFull_d;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pendLeft_q   <= '0;
      pendRight_q  <= '0;
      pendFull_q   <= 1'b0;
      actLeft_q    <= '0;
      actRight_q   <= '0;
      ready_q      <= 1'b0;
      data_q       <= 1'b0;
      frameStart_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      pendLeft_q   <= pendLeft_d;
      pendRight_q  <= pendRight_d;
      pendFull_q   <= pendFull_d;
      actLeft_q    <= actLeft_d;
      actRight_q   <= actRight_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
      frameStart_q <= frameStart_d;
      underrun_q   <= underrun_d;
    end
  end

  assign ready_out       = ready_q;
  assign i2s_data_out    = data_q;
  assign frame_start_out = frameStart_q;
  assign underrun_out    = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: cycle-counted stimulus, captures each
// frame's data/LRCLK bits mid-BCLK and compares against hand-built words.
module tb_i2s_transmitter;
  import i2s_pkg::*;

  logic        clock;
  logic        resetN;
  logic [15:0] leftIn, rightIn;
  logic        validIn;
  logic        readyOut, bclkOut, lrclkOut, dataOut, frameStartOut, underrunOut;

  int          checkCount;
  int          errorCount;
  int          cyc;
  int          streamSent;
  int          streamLimit;
  bit          streamOn;
  logic [63:0] capData, capLr;

  i2s_transmitter dut (
    .clk_in         (clock),
    .rst_in         (resetN),
    .left_in        (leftIn),
    .right_in       (rightIn),
    .valid_in       (validIn),
    .ready_out      (readyOut),
    .i2s_bclk_out   (bclkOut),
    .i2s_lrclk_out  (lrclkOut),
    .i2s_data_out   (dataOut),
    .frame_start_out(frameStartOut),
    .underrun_out   (underrunOut)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] l, input logic [15:0] r);
    validIn = valid;
    leftIn  = l;
    rightIn = r;
  endtask

  function automatic logic [63:0] expWord(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
  endfunction

  // One system cycle; also plays the upstream source while streaming and
  // records data/LRCLK in the middle of every BCLK period.
  task automatic tick();
    logic hs;
    int   bcIdx;
    hs = validIn && readyOut;
    @(posedge clock);
    #1;
    cyc++;
    if (hs && streamOn) begin
      streamSent++;
      if (streamSent >= streamLimit) begin
        streamOn = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0);
      end else begin
        applyStimulus(1'b1, {4'hA, 12'(streamSent + 1)}, {4'h5, 12'((streamSent + 1) * 3)});
      end
    end
    if (cyc % 24 == 12) begin
      bcIdx = (cyc / 24) % 64;
      capData[63 - bcIdx] = dataOut;
      capLr[63 - bcIdx]   = lrclkOut;
    end
  endtask

  task automatic runTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic releaseReset();
    resetN = 1'b1;
    cyc    = 0;
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    cyc         = 0;
    streamOn    = 1'b0;
    streamSent  = 0;
    streamLimit = 0;
    capData     = '0;
    capLr       = '0;
    resetN      = 1'b0;
    applyStimulus(1'b0, 16'h0, 16'h0);

    repeat (10) @(posedge clock);
    #1;
    checkOutput("rst_bclk", 64'(bclkOut), 64'd0);
    checkOutput("rst_lrclk", 64'(lrclkOut), 64'd0);
    checkOutput("rst_data", 64'(dataOut), 64'd0);
    checkOutput("rst_frame_start", 64'(frameStartOut), 64'd0);
    checkOutput("rst_underrun", 64'(underrunOut), 64'd0);
    checkOutput("rst_ready", 64'(readyOut), 64'd0);

    releaseReset();
    tick();
    checkOutput("ready_after_release", 64'(readyOut), 64'd1);
    applyStimulus(1'b1, 16'hA5C3, 16'h8001);
    tick();
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("ready_after_accept", 64'(readyOut), 64'd0);

    runTo(11);   checkOutput("bclk_c11", 64'(bclkOut), 64'd0);
    runTo(12);   checkOutput("bclk_c12", 64'(bclkOut), 64'd1);
    runTo(23);   checkOutput("bclk_c23", 64'(bclkOut), 64'd1);
    runTo(24);   checkOutput("bclk_first_fall", 64'(bclkOut), 64'd0);
    checkOutput("lrclk_first_fall", 64'(lrclkOut), 64'd0);
    runTo(36);   checkOutput("bclk_c36", 64'(bclkOut), 64'd1);
    runTo(48);   checkOutput("bclk_c48", 64'(bclkOut), 64'd0);
    runTo(767);  checkOutput("lrclk_c767", 64'(lrclkOut), 64'd0);
    runTo(768);  checkOutput("lrclk_c768", 64'(lrclkOut), 64'd1);
    runTo(1535); checkOutput("lrclk_c1535", 64'(lrclkOut), 64'd1);

    runTo(1536);
    checkOutput("lrclk_c1536", 64'(lrclkOut), 64'd0);
    checkOutput("b1_frame_start", 64'(frameStartOut), 64'd1);
    checkOutput("b1_underrun", 64'(underrunOut), 64'd0);
    checkOutput("b1_ready", 64'(readyOut), 64'd1);
    checkOutput("frame0_data_zero", capData, 64'd0);
    checkOutput("frame0_lrclk", capLr, 64'h0000_0000_FFFF_FFFF);
    runTo(1537);
    checkOutput("b1_frame_start_end", 64'(frameStartOut), 64'd0);

    runTo(3072);
    checkOutput("frame1_data_pair", capData, expWord(16'hA5C3, 16'h8001));
    checkOutput("frame1_lrclk", capLr, 64'h0000_0000_FFFF_FFFF);
    checkOutput("b2_frame_start", 64'(frameStartOut), 64'd1);
    checkOutput("b2_underrun", 64'(underrunOut), 64'd1);
    runTo(3073);
    checkOutput("b2_underrun_end", 64'(underrunOut), 64'd0);

    runTo(4607);
    applyStimulus(1'b1, 16'h1234, 16'hFEDC);
    runTo(4608);
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("frame2_data_zero", capData, 64'd0);
    checkOutput("b3_coincident_underrun", 64'(underrunOut), 64'd1);
    checkOutput("b3_frame_start", 64'(frameStartOut), 64'd1);
    checkOutput("b3_ready_after_accept", 64'(readyOut), 64'd0);

    runTo(6144);
    checkOutput("frame3_data_zero", capData, 64'd0);
    checkOutput("b4_underrun", 64'(underrunOut), 64'd0);
    checkOutput("b4_ready", 64'(readyOut), 64'd1);

    runTo(6145);
    streamOn    = 1'b1;
    streamSent  = 0;
    streamLimit = 5;
    applyStimulus(1'b1, 16'hA001, 16'h5003);
    runTo(6146);
    checkOutput("bp_ready_low", 64'(readyOut), 64'd0);
    checkOutput("bp_accepts_c6146", 64'(streamSent), 64'd1);
    runTo(7000);
    checkOutput("bp_ready_hold", 64'(readyOut), 64'd0);
    runTo(7679);
    checkOutput("bp_accepts_c7679", 64'(streamSent), 64'd1);

    runTo(7680);
    checkOutput("frame4_coincident_pair", capData, expWord(16'h1234, 16'hFEDC));
    checkOutput("b5_underrun", 64'(underrunOut), 64'd0);
    checkOutput("b5_ready", 64'(readyOut), 64'd1);
    runTo(7681);
    checkOutput("bp_ready_relow", 64'(readyOut), 64'd0);
    checkOutput("bp_accepts_c7681", 64'(streamSent), 64'd2);

    runTo(9216);
    checkOutput("frame5_pair1", capData, expWord(16'hA001, 16'h5003));
    checkOutput("b6_underrun", 64'(underrunOut), 64'd0);
    checkOutput("bp_accepts_c9216", 64'(streamSent), 64'd2);
    runTo(10752);
    checkOutput("frame6_pair2", capData, expWord(16'hA002, 16'h5006));
    checkOutput("bp_accepts_c10752", 64'(streamSent), 64'd3);
    runTo(12288);
    checkOutput("frame7_pair3", capData, expWord(16'hA003, 16'h5009));
    checkOutput("b8_underrun", 64'(underrunOut), 64'd0);
    checkOutput("bp_accepts_c12288", 64'(streamSent), 64'd4);
    runTo(12290);
    checkOutput("bp_accepts_c12290", 64'(streamSent), 64'd5);
    checkOutput("bp_ready_pending5", 64'(readyOut), 64'd0);

    runTo(12782);
    checkOutput("pre_reset_bclk", 64'(bclkOut), 64'd1);
    resetN = 1'b0;
    tick();
    checkOutput("midrst_bclk", 64'(bclkOut), 64'd0);
    checkOutput("midrst_lrclk", 64'(lrclkOut), 64'd0);
    checkOutput("midrst_data", 64'(dataOut), 64'd0);
    checkOutput("midrst_ready", 64'(readyOut), 64'd0);
    repeat (4) tick();

    releaseReset();
    tick();
    checkOutput("midrst_ready_release", 64'(readyOut), 64'd1);
    runTo(12);   checkOutput("midrst_bclk_c12", 64'(bclkOut), 64'd1);
    runTo(24);   checkOutput("midrst_first_fall", 64'(bclkOut), 64'd0);
    runTo(767);  checkOutput("midrst_lrclk_c767", 64'(lrclkOut), 64'd0);
    runTo(768);  checkOutput("midrst_lrclk_c768", 64'(lrclkOut), 64'd1);
    runTo(1536);
    checkOutput("midrst_frame0_zero", capData, 64'd0);
    checkOutput("midrst_b1_underrun", 64'(underrunOut), 64'd1);
    checkOutput("midrst_b1_frame_start", 64'(frameStartOut), 64'd1);
    runTo(3072);
    checkOutput("midrst_frame1_zero", capData, 64'd0);
    checkOutput("midrst_b2_underrun", 64'(underrunOut), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
